example_apb_regs: RTL and testbench
===================================

Name: example_apb_regs

Overview:
- APB3 slave register bank for the "example" register map (8 x 32-bit words, 3-bit word address).
- Holds the complete example register structure and decodes bus reads/writes with the package read/write functions.
- Drives the structure to downstream logic and emits per-register write pulses.
- Sits directly upstream of every consumer of the example register structure.

Parameters:
- APB_ADDR_WIDTH, 12, byte-address width of paddr; must be >= 5.

Ports:
- clk  in  1  system clock, rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- psel  in  1  APB select.
- penable  in  1  APB enable (access phase).
- pwrite  in  1  1 = write, 0 = read.
- paddr  in  APB_ADDR_WIDTH  byte address.
- pwdata  in  32  write data.
- prdata  out  32  read data, registered.
- pready  out  1  transfer complete, registered.
- pslverr  out  1  error response, registered; valid only while pready=1.
- registers  out  $bits(example_struct_type)  current register structure.
- wr_pulse  out  8  one-hot write strobe; bit n = word n.

Behaviour:
- Interface fixed: one clock, clk; reset rst_n, asynchronous, active-low.
- Decode:
  - word index = paddr[4:2]; paddr[1:0] ignored.
  - paddr[APB_ADDR_WIDTH-1:5] != 0 is out of range.
- Reset (async assert):
  - prdata=0, pready=0, pslverr=0, wr_pulse=0, FSM=IDLE.
  - registers loaded from the package reset values: reg0=0, reg1=1, reg2=1, reg3=1, reg4=12, reg7=0.
  - reg5 and reg6 have no reset and hold their value through reset.
- FSM states: IDLE, WAIT (only with the optional feature), RESP.
- IDLE:
  - psel=1 & penable=0 (setup) → latch word index, pwrite, pwdata and the out-of-range flag.
  - Without the feature, go to RESP and at the same edge register pready=1, pslverr=out_of_range, prdata=(read & !err) ? read_example(registers, idx) : 0.
  - penable=1 with no preceding setup is ignored; FSM stays in IDLE.
- RESP (pready=1 for exactly one cycle):
  - If psel & penable & pwrite & !err, commit at this edge: registers <= write_example(pwdata, idx, registers).
  - At the next edge, wr_pulse = 1<<idx for exactly one cycle.
  - Always return to IDLE; pready, pslverr and prdata return to 0 at the next edge.
  - Zero-wait-state latency: setup cycle, then one access cycle.
- Aborted access: psel=0 during RESP → no commit, no wr_pulse, return to IDLE.
- Errors:
  - Out-of-range write → pslverr=1, no register change, no wr_pulse.
  - Out-of-range read → prdata=0, pslverr=1.
- Field widths are narrower than 32 bits where the map defines them: reg2 is 6 bits, reg7 packs nibble2:nibble1:nibble0 into 12 bits.
  - Write uses data[$bits(reg)-1:0]; upper pwdata bits are dropped.
  - Read returns the field zero-extended in prdata[$bits(reg)-1:0].
- Back-to-back transfers: a read in the transfer after a write to the same word returns the new value.
  - APB guarantees a setup cycle, so this holds without bypass logic.
- Reset mid-transfer: asserting rst_n low in RESP aborts the commit and clears outputs immediately; the FSM restarts in IDLE.
- The registers output is a direct flop output with no combinational path from the APB inputs.

Optional Feature:
- Macro: EXAMPLE_REGS_WAIT_STATE_EN.
- Defined:
  - From IDLE, the setup cycle goes to WAIT; pready stays 0 for one access cycle.
  - At the WAIT edge, prdata and pslverr are captured and pready=1; the FSM goes to RESP.
  - Latency is setup + 2 access cycles.
  - psel=0 during WAIT aborts the transfer back to IDLE.
- Undefined: WAIT state absent; latency as above (setup + 1 access cycle).

Test Plan:
- Reset, then read words 0-4 and 7 → prdata = 0, 1, 1, 1, 12, 0; pslverr=0; pready high exactly one cycle per transfer.
- Write 0xDEADBEEF to word 0, then read it → registers.reg0=0xDEADBEEF, prdata=0xDEADBEEF, wr_pulse=8'h01 for one cycle after commit.
- Write 0xFFFFFFFF to word 2 (0x08), then read → prdata=0x0000003F; write 0xFFFFFFFF to word 7 (0x1C) → prdata=0x00000FFF.
- Write 0x1234 to paddr 0x020 → pslverr=1, registers unchanged, wr_pulse=0; read of 0x020 → prdata=0, pslverr=1.
- Write 0xA5 to word 5, pulse rst_n low mid-idle → reg5 still 0xA5; reg4=12.
- Write word 1 with rst_n asserted during RESP → reg1 stays 1, no wr_pulse.
- With EXAMPLE_REGS_WAIT_STATE_EN: read word 4 → pready rises on the 2nd access cycle, prdata=12.
- With EXAMPLE_REGS_WAIT_STATE_EN: psel dropped during WAIT → no pready, no write.

Source files
------------

// File: rtl/example_apb_regs.sv
// -----------------------------------------------------------------------------
// example_apb_regs
//   APB3 slave register bank for the "example" register map: eight 32-bit
//   word slots at byte addresses 0x00..0x1C (word index = paddr[4:2]).
//   Holds the register structure, serves bus reads/writes through
//   read_example/write_example, drives the structure to downstream logic and
//   emits a one-hot write strobe one cycle after each committed write.
//
//   Optional feature: define EXAMPLE_REGS_WAIT_STATE_EN to insert one wait
//   state (setup + 2 access cycles). Default build is zero-wait-state.
//
// Ports
//   clk        rising-edge system clock
//   rst_n      asynchronous active-low reset
//   psel       APB select
//   penable    APB enable (access phase)
//   pwrite     1 = write, 0 = read
//   paddr      byte address; bits above [4] must be zero, else error response
//   pwdata     write data
//   prdata     registered read data (zero for writes and errors)
//   pready     registered transfer-complete, high for one cycle per transfer
//   pslverr    registered error response, valid while pready = 1
//   registers  packed example_struct_type, MSB first:
//                reg0[209:178] reg1[177:146] reg2[145:140] reg3[139:108]
//                reg4[107:76]  reg5[75:44]   reg6[43:12]   reg7[11:0]
//   wr_pulse   one-hot write strobe, bit n = word n
// -----------------------------------------------------------------------------
module example_apb_regs #(
  parameter int unsigned APB_ADDR_WIDTH = 12
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      psel,
  input  logic                      penable,
  input  logic                      pwrite,
  input  logic [APB_ADDR_WIDTH-1:0] paddr,
  input  logic [31:0]               pwdata,
  output logic [31:0]               prdata,
  output logic                      pready,
  output logic                      pslverr,
  output logic [209:0]              registers,
  output logic [7:0]                wr_pulse
);

  // ---------------------------------------------------------------------------
  // Register map
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic [3:0] nibble2;
    logic [3:0] nibble1;
    logic [3:0] nibble0;
  } example_reg7_t;

  typedef struct packed {
    logic [31:0]   reg0;
    logic [31:0]   reg1;
    logic [5:0]    reg2;
    logic [31:0]   reg3;
    logic [31:0]   reg4;
    logic [31:0]   reg5;
    logic [31:0]   reg6;
    example_reg7_t reg7;
  } example_struct_type;

  localparam logic [31:0]   RST_REG0 = 32'd0;
  localparam logic [31:0]   RST_REG1 = 32'd1;
  localparam logic [5:0]    RST_REG2 = 6'd1;
  localparam logic [31:0]   RST_REG3 = 32'd1;
  localparam logic [31:0]   RST_REG4 = 32'd12;
  localparam example_reg7_t RST_REG7 = '0;

  // Fields narrower than 32 bits are returned zero-extended.
  function automatic logic [31:0] read_example(input example_struct_type regs,
                                               input logic [2:0]         idx);
    logic [31:0] data;
    data = '0;
    case (idx)
      3'd0: data = regs.reg0;
      3'd1: data = regs.reg1;
      3'd2: data = {26'd0, regs.reg2};
      3'd3: data = regs.reg3;
      3'd4: data = regs.reg4;
      3'd5: data = regs.reg5;
      3'd6: data = regs.reg6;
      3'd7: data = {20'd0, regs.reg7};
    endcase
    return data;
  endfunction

  // Only the addressed field changes; bits beyond the field width are dropped.
  function automatic example_struct_type write_example(input logic [31:0]        data,
                                                       input logic [2:0]         idx,
                                                       input example_struct_type regs);
    example_struct_type r;
    r = regs;
    case (idx)
      3'd0: r.reg0 = data;
      3'd1: r.reg1 = data;
      3'd2: r.reg2 = data[5:0];
      3'd3: r.reg3 = data;
      3'd4: r.reg4 = data;
      3'd5: r.reg5 = data;
      3'd6: r.reg6 = data;
      3'd7: r.reg7 = example_reg7_t'(data[11:0]);
    endcase
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
`ifdef EXAMPLE_REGS_WAIT_STATE_EN
    S_WAIT = 2'd1,
`endif
    S_RESP = 2'd2
  } state_e;

  state_e        state_q;
  logic [2:0]    idx_q;
  logic          wr_q;
  logic [31:0]   wdata_q;
  logic          oor_q;
  logic [31:0]   prdata_q;
  logic          pready_q;
  logic          pslverr_q;
  logic [7:0]    pulse_q;
  logic [7:0]    wr_pulse_q;

  // Fields are kept as separate flops so reg5/reg6 can live without reset.
  logic [31:0]   reg0_q;
  logic [31:0]   reg1_q;
  logic [5:0]    reg2_q;
  logic [31:0]   reg3_q;
  logic [31:0]   reg4_q;
  logic [31:0]   reg5_q;
  logic [31:0]   reg6_q;
  example_reg7_t reg7_q;

  example_struct_type regs_view;
  example_struct_type regs_d;
  logic               commit;
  logic               setup;
  logic [2:0]         addr_idx;
  logic               addr_oor;
  logic               unused_addr_lsb;
`ifdef EXAMPLE_REGS_WAIT_STATE_EN
  logic [31:0]        wait_rdata;
`else
  logic [31:0]        setup_rdata;
`endif

  // ---------------------------------------------------------------------------
  // Combinational decode
  // ---------------------------------------------------------------------------
  assign setup           = psel && !penable;
  assign addr_idx        = paddr[4:2];
  assign addr_oor        = (paddr >> 5) != '0;
  assign unused_addr_lsb = ^paddr[1:0];

  always_comb begin
    regs_view      = '0;
    regs_view.reg0 = reg0_q;
    regs_view.reg1 = reg1_q;
    regs_view.reg2 = reg2_q;
    regs_view.reg3 = reg3_q;
    regs_view.reg4 = reg4_q;
    regs_view.reg5 = reg5_q;
    regs_view.reg6 = reg6_q;
    regs_view.reg7 = reg7_q;
  end

  always_comb begin
    regs_d = write_example(wdata_q, idx_q, regs_view);
    commit = (state_q == S_RESP) && psel && penable && wr_q && !oor_q;
  end

`ifdef EXAMPLE_REGS_WAIT_STATE_EN
  assign wait_rdata  = (!wr_q && !oor_q) ? read_example(regs_view, idx_q) : '0;
`else
  assign setup_rdata = (!pwrite && !addr_oor) ? read_example(regs_view, addr_idx) : '0;
`endif

  // ---------------------------------------------------------------------------
  // Bus FSM, response outputs and resettable fields
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      wr_q       <= 1'b0;
      wdata_q    <= '0;
      oor_q      <= 1'b0;
      prdata_q   <= '0;
      pready_q   <= 1'b0;
      pslverr_q  <= 1'b0;
      pulse_q    <= '0;
      wr_pulse_q <= '0;
      reg0_q     <= RST_REG0;
      reg1_q     <= RST_REG1;
      reg2_q     <= RST_REG2;
      reg3_q     <= RST_REG3;
      reg4_q     <= RST_REG4;
      reg7_q     <= RST_REG7;
    end else begin
      // Strobe trails the commit edge by one cycle.
      wr_pulse_q <= pulse_q;
      pulse_q    <= '0;
      case (state_q)
        S_IDLE: begin
          if (setup) begin
            idx_q   <= addr_idx;
            wr_q    <= pwrite;
            wdata_q <= pwdata;
            oor_q   <= addr_oor;
`ifdef EXAMPLE_REGS_WAIT_STATE_EN
            state_q <= S_WAIT;
`else
            state_q   <= S_RESP;
            pready_q  <= 1'b1;
            pslverr_q <= addr_oor;
            prdata_q  <= setup_rdata;
`endif
          end
        end
`ifdef EXAMPLE_REGS_WAIT_STATE_EN
        S_WAIT: begin
          if (psel) begin
            state_q   <= S_RESP;
            pready_q  <= 1'b1;
            pslverr_q <= oor_q;
            prdata_q  <= wait_rdata;
          end else begin
            state_q <= S_IDLE;
          end
        end
`endif
        S_RESP: begin
          state_q   <= S_IDLE;
          pready_q  <= 1'b0;
          pslverr_q <= 1'b0;
          prdata_q  <= '0;
          if (commit) begin
            pulse_q <= 8'd1 << idx_q;
            reg0_q  <= regs_d.reg0;
            reg1_q  <= regs_d.reg1;
            reg2_q  <= regs_d.reg2;
            reg3_q  <= regs_d.reg3;
            reg4_q  <= regs_d.reg4;
            reg7_q  <= regs_d.reg7;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // reg5/reg6 carry no reset and keep their contents across rst_n.
  // commit is derived from state_q, so a write cannot land while rst_n is low.
  always_ff @(posedge clk) begin
    if (commit) begin
      reg5_q <= regs_d.reg5;
      reg6_q <= regs_d.reg6;
    end
  end

  assign prdata    = prdata_q;
  assign pready    = pready_q;
  assign pslverr   = pslverr_q;
  assign wr_pulse  = wr_pulse_q;
  assign registers = regs_view;

endmodule

// File: tb/tb_example_apb_regs.sv
module tb_example_apb_regs;

  logic         clk;
  logic         rst_n;
  logic         psel;
  logic         penable;
  logic         pwrite;
  logic [11:0]  paddr;
  logic [31:0]  pwdata;
  logic [31:0]  prdata;
  logic         pready;
  logic         pslverr;
  logic [209:0] registers;
  logic [7:0]   wr_pulse;

  int checks = 0;
  int errors = 0;

`ifdef EXAMPLE_REGS_WAIT_STATE_EN
  localparam int LAT          = 1;  // extra access cycles before pready
  localparam int ABORT_READY  = 0;  // pready cycles seen when psel drops after setup
`else
  localparam int LAT          = 0;
  localparam int ABORT_READY  = 1;
`endif

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mdl   [8];
  bit          known [8];

  example_apb_regs #(.APB_ADDR_WIDTH(12)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .psel      (psel),
    .penable   (penable),
    .pwrite    (pwrite),
    .paddr     (paddr),
    .pwdata    (pwdata),
    .prdata    (prdata),
    .pready    (pready),
    .pslverr   (pslverr),
    .registers (registers),
    .wr_pulse  (wr_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] field_mask(input int w);
    case (w)
      2:       return 32'h0000_003F;
      7:       return 32'h0000_0FFF;
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

  function automatic logic [31:0] field_of(input logic [209:0] v, input int w);
    logic [209:0] s;
    int lo;
    case (w)
      0: lo = 178;
      1: lo = 146;
      2: lo = 140;
      3: lo = 108;
      4: lo = 76;
      5: lo = 44;
      6: lo = 12;
      default: lo = 0;
    endcase
    s = v >> lo;
    return s[31:0] & field_mask(w);
  endfunction

  task automatic model_reset();
    mdl[0] = 32'd0;  known[0] = 1'b1;
    mdl[1] = 32'd1;  known[1] = 1'b1;
    mdl[2] = 32'd1;  known[2] = 1'b1;
    mdl[3] = 32'd1;  known[3] = 1'b1;
    mdl[4] = 32'd12; known[4] = 1'b1;
    mdl[7] = 32'd0;  known[7] = 1'b1;
  endtask

  // Scoreboard consumer: waits (bounded) for pready and compares against the
  // oldest expected response. Returns the number of extra access cycles.
  task automatic sb_consume(input string name, output int n);
    exp_t e;
    n = 0;
    while (pready !== 1'b1 && n < 6) begin
      @(posedge clk); #1;
      n++;
    end
    e = sb.pop_front();
    checks++;
    if (pready !== 1'b1) begin
      errors++;
      $display("FAIL %s pready: got %b expected 1 within 6 cycles", name, pready);
    end else begin
      checks++;
      if (prdata !== e.rdata) begin
        errors++;
        $display("FAIL %s prdata: got %h expected %h", name, prdata, e.rdata);
      end
      checks++;
      if (pslverr !== e.err) begin
        errors++;
        $display("FAIL %s pslverr: got %b expected %b", name, pslverr, e.err);
      end
      checks++;
      if (n != LAT) begin
        errors++;
        $display("FAIL %s latency: got %0d expected %0d wait cycles", name, n, LAT);
      end
    end
  endtask

  task automatic push_expected(input bit wr, input logic [11:0] addr);
    exp_t e;
    int   idx;
    bit   oor;
    idx     = int'(addr[4:2]);
    oor     = (addr >> 5) != 12'd0;
    e.err   = oor;
    e.rdata = (!wr && !oor) ? mdl[idx] : 32'd0;
    sb.push_back(e);
  endtask

  task automatic apb_xfer(input bit wr, input logic [11:0] addr,
                          input logic [31:0] data, input string name);
    int         n;
    int         idx;
    bit         oor;
    logic [7:0] exp_pulse;
    idx = int'(addr[4:2]);
    oor = (addr >> 5) != 12'd0;
    push_expected(wr, addr);
    @(posedge clk); #1;
    checks++;
    if (wr_pulse !== 8'h00) begin
      errors++;
      $display("FAIL %s idle_wr_pulse: got %h expected 00", name, wr_pulse);
    end
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = data;
    @(posedge clk); #1;
    penable = 1'b1;
    sb_consume(name, n);
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
    checks++;
    if (pready !== 1'b0) begin
      errors++;
      $display("FAIL %s pready_width: got %b expected 0", name, pready);
    end
    exp_pulse = 8'h00;
    if (wr && !oor) begin
      mdl[idx]   = data & field_mask(idx);
      known[idx] = 1'b1;
      exp_pulse  = 8'd1 << idx;
    end
    @(posedge clk); #1;
    checks++;
    if (wr_pulse !== exp_pulse) begin
      errors++;
      $display("FAIL %s wr_pulse: got %h expected %h", name, wr_pulse, exp_pulse);
    end
    for (int w = 0; w < 8; w++) begin
      if (known[w]) begin
        checks++;
        if (field_of(registers, w) !== mdl[w]) begin
          errors++;
          $display("FAIL %s reg%0d: got %h expected %h", name, w, field_of(registers, w), mdl[w]);
        end
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({prdata, pready, pslverr, wr_pulse} !== 42'd0) begin
      errors++;
      $display("FAIL reset_outputs: got prdata=%h pready=%b pslverr=%b wr_pulse=%h expected all 0",
               prdata, pready, pslverr, wr_pulse);
    end
    rst_n = 1'b1;
    model_reset();
    foreach (known[w]) begin
      if (known[w]) begin
        checks++;
        if (field_of(registers, w) !== mdl[w]) begin
          errors++;
          $display("FAIL reset_reg%0d: got %h expected %h", w, field_of(registers, w), mdl[w]);
        end
      end
    end
    apb_xfer(1'b0, 12'h000, 32'd0, "rst_rd0");
    apb_xfer(1'b0, 12'h004, 32'd0, "rst_rd1");
    apb_xfer(1'b0, 12'h008, 32'd0, "rst_rd2");
    apb_xfer(1'b0, 12'h00C, 32'd0, "rst_rd3");
    apb_xfer(1'b0, 12'h010, 32'd0, "rst_rd4");
    apb_xfer(1'b0, 12'h01C, 32'd0, "rst_rd7");
  endtask

  task automatic test_write_read();
    apb_xfer(1'b1, 12'h000, 32'hDEAD_BEEF, "wr0");
    apb_xfer(1'b0, 12'h000, 32'd0,         "rd0");
    apb_xfer(1'b1, 12'h010, 32'h0BAD_F00D, "wr4");
    apb_xfer(1'b0, 12'h012, 32'd0,         "rd4_lsb_ignored");
  endtask

  task automatic test_field_width();
    apb_xfer(1'b1, 12'h008, 32'hFFFF_FFFF, "wr2_wide");
    apb_xfer(1'b0, 12'h008, 32'd0,         "rd2_wide");
    apb_xfer(1'b1, 12'h01C, 32'hFFFF_FFFF, "wr7_wide");
    apb_xfer(1'b0, 12'h01F, 32'd0,         "rd7_wide");
  endtask

  task automatic test_out_of_range();
    apb_xfer(1'b1, 12'h020, 32'h0000_1234, "wr_oor");
    apb_xfer(1'b0, 12'h020, 32'd0,         "rd_oor");
    apb_xfer(1'b1, 12'h800, 32'hFFFF_FFFF, "wr_oor_msb");
  endtask

  task automatic test_no_reset_regs();
    apb_xfer(1'b1, 12'h014, 32'h0000_00A5, "wr5");
    apb_xfer(1'b1, 12'h018, 32'h6666_0006, "wr6");
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    checks++;
    if (field_of(registers, 5) !== 32'h0000_00A5) begin
      errors++;
      $display("FAIL noreset_reg5: got %h expected 000000a5", field_of(registers, 5));
    end
    checks++;
    if (field_of(registers, 4) !== 32'd12) begin
      errors++;
      $display("FAIL noreset_reg4: got %h expected 0000000c", field_of(registers, 4));
    end
    apb_xfer(1'b0, 12'h014, 32'd0, "rd5_after_reset");
    apb_xfer(1'b0, 12'h018, 32'd0, "rd6_after_reset");
  endtask

  task automatic test_reset_in_resp();
    int n;
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 12'h004; pwdata = 32'h5555_5555;
    @(posedge clk); #1;
    penable = 1'b1;
    n = 0;
    while (pready !== 1'b1 && n < 6) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (pready !== 1'b1) begin
      errors++;
      $display("FAIL rst_resp_ready: got %b expected 1", pready);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({prdata, pready, pslverr, wr_pulse} !== 42'd0) begin
      errors++;
      $display("FAIL rst_resp_clear: got prdata=%h pready=%b pslverr=%b wr_pulse=%h expected all 0",
               prdata, pready, pslverr, wr_pulse);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    psel = 1'b0; penable = 1'b0;
    model_reset();
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (wr_pulse !== 8'h00) begin
        errors++;
        $display("FAIL rst_resp_pulse: got %h expected 00", wr_pulse);
      end
      @(posedge clk); #1;
    end
    checks++;
    if (field_of(registers, 1) !== 32'd1) begin
      errors++;
      $display("FAIL rst_resp_reg1: got %h expected 00000001", field_of(registers, 1));
    end
    apb_xfer(1'b0, 12'h004, 32'd0, "rd1_after_rst_resp");
  endtask

  task automatic test_abort();
    int seen;
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 12'h00C; pwdata = 32'h7777_7777;
    @(posedge clk); #1;
    psel = 1'b0;
    seen = 0;
    for (int c = 0; c < 4; c++) begin
      if (pready === 1'b1) seen++;
      checks++;
      if (wr_pulse !== 8'h00) begin
        errors++;
        $display("FAIL abort_pulse: got %h expected 00", wr_pulse);
      end
      @(posedge clk); #1;
    end
    checks++;
    if (seen != ABORT_READY) begin
      errors++;
      $display("FAIL abort_ready: got %0d pready cycles expected %0d", seen, ABORT_READY);
    end
    checks++;
    if (field_of(registers, 3) !== mdl[3]) begin
      errors++;
      $display("FAIL abort_reg3: got %h expected %h", field_of(registers, 3), mdl[3]);
    end
  endtask

  task automatic test_penable_no_setup();
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 12'h000; pwdata = 32'h0101_0101;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      checks++;
      if (pready !== 1'b0) begin
        errors++;
        $display("FAIL nosetup_ready: got %b expected 0", pready);
      end
    end
    psel = 1'b0; penable = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (field_of(registers, 0) !== mdl[0] || wr_pulse !== 8'h00) begin
      errors++;
      $display("FAIL nosetup_write: got reg0=%h wr_pulse=%h expected reg0=%h wr_pulse=00",
               field_of(registers, 0), wr_pulse, mdl[0]);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    push_expected(1'b1, 12'h00C);
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 12'h00C; pwdata = 32'hCAFE_F00D;
    @(posedge clk); #1;
    penable = 1'b1;
    sb_consume("b2b_wr3", n);
    mdl[3] = 32'hCAFE_F00D;
    push_expected(1'b0, 12'h00C);
    @(posedge clk); #1;
    penable = 1'b0; pwrite = 1'b0;
    @(posedge clk); #1;
    penable = 1'b1;
    checks++;
    if (wr_pulse !== 8'h08) begin
      errors++;
      $display("FAIL b2b_wr_pulse: got %h expected 08", wr_pulse);
    end
    sb_consume("b2b_rd3", n);
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
    checks++;
    if (wr_pulse !== 8'h00) begin
      errors++;
      $display("FAIL b2b_pulse_width: got %h expected 00", wr_pulse);
    end
  endtask

`ifdef EXAMPLE_REGS_WAIT_STATE_EN
  task automatic test_wait_state();
    apb_xfer(1'b0, 12'h010, 32'd0,         "ws_rd4");
    apb_xfer(1'b1, 12'h018, 32'h1234_5678, "ws_wr6");
    apb_xfer(1'b0, 12'h018, 32'd0,         "ws_rd6");
  endtask
`endif

  initial begin
    rst_n = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0;
    foreach (known[w]) begin
      known[w] = 1'b0;
      mdl[w]   = 32'd0;
    end
    test_reset();
    test_write_read();
    test_field_width();
    test_out_of_range();
    test_no_reset_regs();
    test_reset_in_resp();
    test_abort();
    test_penable_no_setup();
    test_back_to_back();
`ifdef EXAMPLE_REGS_WAIT_STATE_EN
    test_wait_state();
`endif
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
